// File: rtl/icache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : icache_controller
//  Description : Read-only instruction cache controller. Looks fetches up in
//                an external cache_memory, serves hits in one cycle, refills
//                misses from main memory one word at a time, and picks victims
//                by first-invalid way or a per-set round-robin pointer.
//  Revision    : 1.0  initial release
// ============================================================================
module icache_controller #(
    parameter  int ADDR_SIZE  = 32,
    parameter  int NUM_SETS   = 4,
    parameter  int NUM_WAYS   = 2,
    parameter  int BLOCK_SIZE = 32,
    localparam int SET_SIZE   = $clog2(NUM_SETS),
    localparam int WAY_SIZE   = $clog2(NUM_WAYS),
    localparam int TAG_SIZE   = ADDR_SIZE - SET_SIZE - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_SIZE-1:0]  req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [BLOCK_SIZE-1:0] resp_data,
    output logic [SET_SIZE-1:0]   cm_set,
    output logic [TAG_SIZE-1:0]   cm_tag,
    output logic [WAY_SIZE-1:0]   cm_write_way,
    output logic                  cm_write_enable,
    output logic [BLOCK_SIZE-1:0] cm_write_data,
    input  logic [BLOCK_SIZE-1:0] cm_read_data,
    input  logic                  cm_hit,
    input  logic [WAY_SIZE-1:0]   cm_populate_way,
    input  logic                  cm_populated,
    output logic                  mem_req_valid,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    input  logic                  mem_ack,
    input  logic [BLOCK_SIZE-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_MISS   = 2'd2;
    localparam logic [1:0] S_REFILL = 2'd3;

    logic [1:0]            state_q,  state_d;
    logic [ADDR_SIZE-3:0]  addr_q,   addr_d;     // word address of the request
    logic [WAY_SIZE-1:0]   victim_q, victim_d;
    logic                  use_rr_q, use_rr_d;   // victim came from the rr pointer
    logic [BLOCK_SIZE-1:0] data_q,   data_d;
    logic [31:0]           hit_q,    hit_d;
    logic [31:0]           miss_q,   miss_d;
    logic [WAY_SIZE-1:0]   rr_ptr_q [NUM_SETS];
    logic                  rr_advance;
    logic [SET_SIZE-1:0]   set_q;
    logic                  is_idle;
    logic                  is_lookup_hit;
    logic                  is_refill;
    logic                  unused_offset;

    assign set_q         = addr_q[SET_SIZE-1:0];
    assign is_idle       = (state_q == S_IDLE);
    assign is_lookup_hit = (state_q == S_LOOKUP) && cm_hit;
    assign is_refill     = (state_q == S_REFILL);
    // Byte offset within the word never matters for a word-sized line.
    assign unused_offset = ^req_addr[1:0];

    // The array is addressed combinationally from the live request while idle
    // so the lookup result is already valid in the cycle after acceptance.
    assign cm_set          = is_idle ? req_addr[SET_SIZE+1:2] : set_q;
    assign cm_tag          = is_idle ? req_addr[ADDR_SIZE-1:SET_SIZE+2]
                                     : addr_q[ADDR_SIZE-3:SET_SIZE];
    assign req_ready       = is_idle;
    assign mem_req_valid   = (state_q == S_MISS);
    assign mem_addr        = {addr_q, 2'b00};
    assign cm_write_way    = victim_q;
    // A reset landing on the refill cycle must not leave a line behind.
    assign cm_write_enable = is_refill && rst;
    assign cm_write_data   = is_refill ? data_q : '0;
    assign resp_valid      = is_lookup_hit || is_refill;
    assign resp_data       = is_lookup_hit ? cm_read_data :
                             is_refill     ? data_q       : '0;
    assign hit_count       = hit_q;
    assign miss_count      = miss_q;

    // Next-state, victim choice and saturating statistics.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        victim_d   = victim_q;
        use_rr_d   = use_rr_q;
        data_d     = data_q;
        hit_d      = hit_q;
        miss_d     = miss_q;
        rr_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_SIZE-1:2];
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (cm_hit) begin
                    if (hit_q != 32'hFFFF_FFFF) hit_d = hit_q + 32'd1;
                    state_d = S_IDLE;
                end else begin
                    victim_d = cm_populated ? rr_ptr_q[set_q] : cm_populate_way;
                    use_rr_d = cm_populated;
                    if (miss_q != 32'hFFFF_FFFF) miss_d = miss_q + 32'd1;
                    state_d = S_MISS;
                end
            end
            S_MISS: begin
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    state_d = S_REFILL;
                end
            end
            S_REFILL: begin
                rr_advance = use_rr_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            use_rr_q <= 1'b0;
            data_q   <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) rr_ptr_q[s] <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            victim_q <= victim_d;
            use_rr_q <= use_rr_d;
            data_q   <= data_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            if (rr_advance) rr_ptr_q[set_q] <= rr_ptr_q[set_q] + WAY_SIZE'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_controller
//  Description : Randomized scoreboard bench for icache_controller with a
//                behavioural cache_memory, a memory responder and a
//                reference model of hit/miss, victim choice and counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_icache_controller;

    localparam int NUM_SETS = 4;
    localparam int NUM_WAYS = 2;
    localparam int SET_SIZE = 2;
    localparam int WAY_SIZE = 1;
    localparam int TAG_SIZE = 28;

    logic                clk = 1'b0;
    logic                rst;
    logic                req_valid;
    logic [31:0]         req_addr;
    logic                req_ready;
    logic                resp_valid;
    logic [31:0]         resp_data;
    logic [SET_SIZE-1:0] cm_set;
    logic [TAG_SIZE-1:0] cm_tag;
    logic [WAY_SIZE-1:0] cm_write_way;
    logic                cm_write_enable;
    logic [31:0]         cm_write_data;
    logic [31:0]         cm_read_data;
    logic                cm_hit;
    logic [WAY_SIZE-1:0] cm_populate_way;
    logic                cm_populated;
    logic                mem_req_valid;
    logic [31:0]         mem_addr;
    logic                mem_ack;
    logic [31:0]         mem_rdata;
    logic [31:0]         hit_count;
    logic [31:0]         miss_count;

    icache_controller dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .cm_set(cm_set), .cm_tag(cm_tag), .cm_write_way(cm_write_way),
        .cm_write_enable(cm_write_enable), .cm_write_data(cm_write_data),
        .cm_read_data(cm_read_data), .cm_hit(cm_hit),
        .cm_populate_way(cm_populate_way), .cm_populated(cm_populated),
        .mem_req_valid(mem_req_valid), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Main memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_1000) return 32'hDEAD_BEEF;
        return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // ---------------- behavioural cache_memory ----------------
    logic                mv    [NUM_SETS][NUM_WAYS];
    logic [TAG_SIZE-1:0] mtag  [NUM_SETS][NUM_WAYS];
    logic [31:0]         mdata [NUM_SETS][NUM_WAYS];

    // Combinational lookup, first-invalid way and fullness of the addressed set.
    always_comb begin
        cm_hit          = 1'b0;
        cm_read_data    = '0;
        cm_populate_way = '0;
        cm_populated    = 1'b1;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!mv[cm_set][w]) begin
                cm_populate_way = WAY_SIZE'(w);
                cm_populated    = 1'b0;
            end
            if (mv[cm_set][w] && mtag[cm_set][w] == cm_tag) begin
                cm_hit       = 1'b1;
                cm_read_data = mdata[cm_set][w];
            end
        end
    end

    // Array write port and reset.
    always @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++)
                for (int w = 0; w < NUM_WAYS; w++) mv[s][w] <= 1'b0;
        end else if (cm_write_enable) begin
            mv[cm_set][cm_write_way]    <= 1'b1;
            mtag[cm_set][cm_write_way]  <= cm_tag;
            mdata[cm_set][cm_write_way] <= cm_write_data;
        end
    end

    // ---------------- memory responder ----------------
    bit ack_en = 1'b1;
    int delay_cnt = 3;
    int stray_req = 0;
    int stray_done = 0;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (stray_req != stray_done) begin
                mem_ack    = 1'b1;
                mem_rdata  = 32'hBAD0_BAD0;
                stray_done = stray_done + 1;
            end else if (ack_en && rst && mem_req_valid) begin
                if (delay_cnt == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    delay_cnt = $urandom_range(0, 3);
                end else begin
                    delay_cnt--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] data;
        bit          miss;
        logic [31:0] maddr;
        int          way;
    } exp_t;

    exp_t        exp_q[$];
    bit          ref_v   [NUM_SETS][NUM_WAYS];
    logic [27:0] ref_tag [NUM_SETS][NUM_WAYS];
    int          ref_rr  [NUM_SETS];
    int          ref_hits;
    int          ref_misses;

    function automatic void ref_reset();
        for (int s = 0; s < NUM_SETS; s++) begin
            ref_rr[s] = 0;
            for (int w = 0; w < NUM_WAYS; w++) ref_v[s][w] = 1'b0;
        end
        ref_hits   = 0;
        ref_misses = 0;
    endfunction

    function automatic void push_expect(input logic [31:0] a);
        exp_t e;
        int   s;
        int   victim;
        bit   found;
        s      = int'(a[3:2]);
        found  = 1'b0;
        victim = -1;
        for (int w = 0; w < NUM_WAYS; w++)
            if (ref_v[s][w] && ref_tag[s][w] == a[31:4]) found = 1'b1;
        e.data  = mem_word(a);
        e.maddr = {a[31:2], 2'b00};
        e.miss  = !found;
        e.way   = 0;
        if (found) begin
            ref_hits++;
        end else begin
            ref_misses++;
            for (int w = NUM_WAYS - 1; w >= 0; w--) if (!ref_v[s][w]) victim = w;
            if (victim < 0) begin
                victim    = ref_rr[s];
                ref_rr[s] = (ref_rr[s] + 1) % NUM_WAYS;
            end
            ref_v[s][victim]   = 1'b1;
            ref_tag[s][victim] = a[31:4];
            e.way = victim;
        end
        exp_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    int          n_ack, n_wr, acc_cyc, ack_cyc, wr_way;
    logic [31:0] ack_addr, wr_data;
    exp_t        m_e;

    // Samples the DUT one time unit after each falling edge and scores responses.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            exp_q.delete();
            n_ack = 0;
            n_wr  = 0;
        end else begin
            if (req_valid && req_ready) acc_cyc = cyc;
            if (mem_req_valid && mem_ack) begin
                n_ack++;
                ack_cyc  = cyc;
                ack_addr = mem_addr;
            end
            if (cm_write_enable) begin
                n_wr++;
                wr_way  = int'(cm_write_way);
                wr_data = cm_write_data;
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("resp_data", resp_data, m_e.data);
                    chk("miss_handshakes", n_ack, m_e.miss ? 1 : 0);
                    if (m_e.miss) begin
                        chk("mem_addr", ack_addr, m_e.maddr);
                        chk("refill_writes", n_wr, 1);
                        chk("write_way", wr_way, m_e.way);
                        chk("write_data", wr_data, m_e.data);
                        chk("miss_latency", cyc, ack_cyc + 1);
                    end else begin
                        chk("hit_writes", n_wr, 0);
                        chk("hit_latency", cyc, acc_cyc + 1);
                    end
                end
                n_ack = 0;
                n_wr  = 0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic fetch(input logic [31:0] a);
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) fail_now("fetch_ready");
        push_expect(a);
        req_valid = 1'b1;
        req_addr  = a;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !req_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now("drain");
        @(negedge clk);
        #2;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_hit_count"}, hit_count, ref_hits);
        chk({tag, "_miss_count"}, miss_count, ref_misses);
    endtask

    initial begin
        int t;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        ref_reset();
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_write_enable", cm_write_enable, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_write_data", cm_write_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        check_counts("rst");
        rst = 1'b1;

        // Cold miss, then hit, then the second way of set 0.
        fetch(32'h0000_1000);
        drain();
        check_counts("cold");
        fetch(32'h0000_1000);
        drain();
        check_counts("hit");
        fetch(32'h0000_2000);
        fetch(32'h0000_1000);
        fetch(32'h0000_2000);
        drain();
        check_counts("two_way");

        // Round-robin eviction in a full set, then the evicted line misses.
        fetch(32'h0000_3000);
        fetch(32'h0000_4000);
        fetch(32'h0000_1000);
        fetch(32'h0000_1003);
        fetch(32'h0000_5003);
        drain();
        check_counts("evict");

        // Reset while a memory request is outstanding, then a stray ack.
        ack_en = 1'b0;
        fetch(32'h0000_7000);
        t = 0;
        while (!mem_req_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!mem_req_valid) fail_now("wait_mem_req");
        @(negedge clk);
        rst = 1'b0;
        ref_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rstmiss_mem_req_valid", mem_req_valid, 0);
        chk("rstmiss_req_ready", req_ready, 1);
        stray_req = stray_req + 1;
        repeat (4) begin
            @(negedge clk);
            #2;
            chk("rstmiss_resp_valid", resp_valid, 0);
            chk("rstmiss_write_enable", cm_write_enable, 0);
            chk("rstmiss_mem_req_valid_hold", mem_req_valid, 0);
        end
        chk("rstmiss_writes", n_wr, 0);
        check_counts("rstmiss");
        ack_en    = 1'b1;
        delay_cnt = 1;
        fetch(32'h0000_1000);
        drain();
        check_counts("after_rst");

        // Randomized traffic over a small tag pool so sets fill and evict.
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a;
            a = ($urandom_range(1, 5) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            fetch(a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        check_counts("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
